// File: rtl/dmem_bytelane.sv
// Single-port byte-lane data memory for an RV32 load/store unit: zero-fills itself after reset, one request per cycle.
// Optional misalignment/illegal-size checking is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_bytelane #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [31:0]             r_mem [DEPTH];
  logic                    r_rsp_valid;
  logic [31:0]             r_rsp_rdata;
  logic                    r_rsp_fault;

  logic                    w_ready;
  logic                    w_acc;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic                    w_is_b;
  logic                    w_is_h;
  logic                    w_sext;
  logic                    w_fault;
  logic                    w_st_we;
  logic [3:0]              w_be;
  logic [31:0]             w_st_data;
  logic [31:0]             w_word;
  logic [31:0]             w_shift;
  logic [15:0]             w_half;
  logic [31:0]             w_load;
  logic                    w_unused_addr;

  // State register and sweep counter; a reset mid-sweep restarts from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      CLEAR: if (r_clr_cnt == '1) w_state_nxt = READY;
      READY: w_ready = 1'b1;
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign req_ready     = w_ready;
  assign w_acc         = req_valid && w_ready;
  assign w_idx         = req_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  // Size decode: anything that is not a legal byte/half code is handled as a full word.
  always_comb begin
    w_is_b = req_we ? (req_funct3 == 3'd0) : (req_funct3 == 3'd0 || req_funct3 == 3'd4);
    w_is_h = req_we ? (req_funct3 == 3'd1) : (req_funct3 == 3'd1 || req_funct3 == 3'd5);
    w_sext = !req_funct3[2];
  end

`ifdef DMEM_MISALIGN_CHK_EN
  always_comb begin
    w_fault = 1'b0;
    if (req_we) begin
      if (req_funct3 >= 3'd3)                          w_fault = 1'b1;
      else if (req_funct3 == 3'd1 && req_addr[0])      w_fault = 1'b1;
      else if (req_funct3 == 3'd2 && req_addr[1:0] != 2'd0) w_fault = 1'b1;
    end else begin
      case (req_funct3)
        3'd1, 3'd5: w_fault = req_addr[0];
        3'd2:       w_fault = (req_addr[1:0] != 2'd0);
        3'd3, 3'd6, 3'd7: w_fault = 1'b1;
        default:    w_fault = 1'b0;
      endcase
    end
  end
`else
  assign w_fault = 1'b0;
`endif

  // Store lane steering: data is replicated across lanes and the byte enables pick the target.
  always_comb begin
    w_be      = 4'b1111;
    w_st_data = req_wdata;
    if (w_is_b) begin
      w_be      = 4'b0001 << req_addr[1:0];
      w_st_data = {4{req_wdata[7:0]}};
    end else if (w_is_h) begin
      w_be      = req_addr[1] ? 4'b1100 : 4'b0011;
      w_st_data = {2{req_wdata[15:0]}};
    end
  end

  assign w_st_we = w_acc && req_we && !w_fault && !rst;

  // NOTE: the storage array carries no reset; the CLEAR sweep zero-fills it instead.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR && !rst) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
      end
    end
  end

  // Load formatting from the addressed word.
  always_comb begin
    w_word  = r_mem[w_idx];
    w_shift = w_word >> {req_addr[1:0], 3'b000};
    w_half  = req_addr[1] ? w_word[31:16] : w_word[15:0];
    if (w_is_b)      w_load = {{24{w_sext & w_shift[7]}}, w_shift[7:0]};
    else if (w_is_h) w_load = {{16{w_sext & w_half[15]}}, w_half};
    else             w_load = w_word;
  end

  // Response stage: rdata only moves on an accepted request, otherwise it holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      r_rsp_valid <= w_acc;
      if (w_acc) begin
        r_rsp_fault <= w_fault;
        r_rsp_rdata <= (req_we || w_fault) ? 32'd0 : w_load;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane (ADDR_WIDTH=4): byte-level reference model plus response scoreboard.
// Fault expectations follow DMEM_MISALIGN_CHK_EN when it is defined for the build.
module tb_dmem_bytelane;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  dmem_bytelane #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mem_b [64];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] last_exp = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Byte-addressed reference: size picks 1/2/4 bytes at the naturally aligned base.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic flt);
    int n;
    int base;
    logic [31:0] v;
    flt = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    if (we) flt = (f3 >= 3'd3) || (f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
    else    flt = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ||
                  ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
`endif
    if (we) n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    n = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    base = int'(a[5:0]) & ~(n - 1);
    rd = 32'd0;
    if (!flt) begin
      if (we) begin
        for (int k = 0; k < n; k++) mem_b[base + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mem_b[base + k];
        if (n < 4 && !f3[2] && v[8*n-1])
          for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
        rd = v;
      end
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mem_b[i] = 8'h00;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    model(we, f3, a, wd, e.rdata, e.fault);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_ready", req_ready, 32'd0);
    check("rst_fault", rsp_fault, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    model_clear();
  endtask

  // Counts cycles from reset release until req_ready rises; expected to be the full depth.
  task automatic wait_sweep(input string tag);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, 32'd16);
  endtask

  // Response monitor: one check of rsp_valid per cycle, then either data/fault or hold.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (rst) last_exp = 32'd0;
      check("rsp_valid", rsp_valid, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        e = q.pop_front();
        if (rsp_valid) begin
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_fault", rsp_fault, {31'd0, e.fault});
          last_exp = e.rdata;
        end
      end else begin
        check("rdata_hold", rsp_rdata, last_exp);
      end
    end
  end

  initial begin
    model_clear();
    do_reset();
    mon_en = 1'b1;

    // A store offered throughout the sweep must be ignored.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h3C;
    req_wdata  = 32'hFFFF_FFFF;
    wait_sweep("sweep_len");
    req_valid = 1'b0;

    for (int i = 0; i < 16; i++) issue(1'b0, 3'd2, 32'(i * 4), 32'd0);
    idle(2);

    issue(1'b1, 3'd2, 32'h8, 32'h8899_AABB);
    issue(1'b0, 3'd0, 32'h9, 32'd0);
    issue(1'b0, 3'd4, 32'h9, 32'd0);
    issue(1'b0, 3'd1, 32'hA, 32'd0);
    issue(1'b0, 3'd5, 32'hA, 32'd0);
    idle(3);

    issue(1'b1, 3'd2, 32'h0, 32'h1122_3344);
    issue(1'b1, 3'd0, 32'h2, 32'h0000_00EE);
    issue(1'b1, 3'd1, 32'h0, 32'h0000_5566);
    issue(1'b0, 3'd2, 32'h0, 32'd0);
    idle(1);

    issue(1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF);
    issue(1'b0, 3'd2, 32'h0, 32'd0);
    idle(1);

    issue(1'b1, 3'd2, 32'h4, 32'h0102_0304);
    issue(1'b1, 3'd2, 32'h6, 32'hFFFF_FFFF);
    issue(1'b0, 3'd2, 32'h4, 32'd0);
    idle(2);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
    end
    idle(3);

    // Request offered in the reset cycle gets no response.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h0;
    rst        = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b0;
    model_clear();
    wait_sweep("sweep_after_inflight");
    issue(1'b0, 3'd2, 32'h8, 32'd0);
    idle(2);

    // Reset while the sweep counter sits at 7.
    do_reset();
    repeat (7) @(posedge clk);
    do_reset();
    wait_sweep("sweep_restart");
    issue(1'b0, 3'd2, 32'h0, 32'd0);
    issue(1'b0, 3'd2, 32'h3C, 32'd0);
    idle(3);

    check("drain", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
